dp_run_ctrl: RTL and testbench

Run/step/breakpoint controller for the single-cycle RV32I `Datapath`. It replaces a free-running clock with a clock-enable (`cpu_en`). The datapath can free-run, execute N instructions, or stop on up to `NUM_BP` PC breakpoints. The block sits between the top-level clock/reset and the datapath's state-update enables (PC register, register file, data-memory write). It also provides a retired-instruction counter for debug and benches.

---
 rtl/dp_run_ctrl.sv | 116 +++++++++++
 tb/tb_dp_run_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dp_run_ctrl.sv
// Run/step/breakpoint controller: gates the single-cycle datapath through cpu_en
// and counts retired instructions.
module dp_run_ctrl #(
    parameter int XLEN      = 32,
    parameter int NUM_BP    = 4,
    parameter int CNT_W     = 16,
    parameter bit RESET_RUN = 1'b1,
    localparam int IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             run_req,
    input  logic             step_req,
    input  logic [CNT_W-1:0] step_count,
    input  logic             halt_req,
    input  logic             bp_we,
    input  logic [IDX_W-1:0] bp_idx,
    input  logic [XLEN-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic             halted,
    output logic             bp_hit,
    output logic [IDX_W-1:0] bp_hit_idx,
    output logic [31:0]      retired_cnt
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;
    logic              skip_bp;
    logic [CNT_W-1:0]  remaining;
    logic              bp_match;
    logic [IDX_W-1:0]  match_idx;
    logic              bp_stop;

    // Scan from the top slot down so the lowest matching slot ends up in match_idx.
    always_comb begin
        bp_match  = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc_i)) begin
                bp_match  = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign bp_stop = bp_match && !skip_bp;
    assign cpu_en  = (state != HALT) && !bp_stop;
    assign state_o = state;
    assign halted  = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_RUN ? RUN : HALT;
            skip_bp     <= 1'b1;
            remaining   <= '0;
            bp_hit      <= 1'b0;
            bp_hit_idx  <= '0;
            retired_cnt <= '0;
            bp_en_q     <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            bp_hit <= 1'b0;

            if (cpu_en) begin
                retired_cnt <= retired_cnt + 32'd1;
            end

            if (bp_we && (32'(bp_idx) < NUM_BP)) begin
                bp_addr_q[bp_idx] <= bp_addr;
                bp_en_q[bp_idx]   <= bp_en;
            end

            // skip_bp lets the instruction sitting at a breakpoint PC retire on resume.
            case (state)
                HALT: begin
                    if (step_req) begin
                        state     <= STEP;
                        remaining <= (step_count == '0) ? CNT_W'(1) : step_count;
                        skip_bp   <= 1'b1;
                    end else if (run_req) begin
                        state   <= RUN;
                        skip_bp <= 1'b1;
                    end
                end
                default: begin
                    skip_bp <= 1'b0;
                    if (halt_req) begin
                        state <= HALT;
                    end else if (bp_stop) begin
                        state      <= HALT;
                        bp_hit     <= 1'b1;
                        bp_hit_idx <= match_idx;
                    end else if ((state == STEP) && cpu_en) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= HALT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Bench for dp_run_ctrl: a looping PC model feeds pc_i, a queue scoreboard
// holds the expected cpu_en for each cycle.
module tb_dp_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        run_req;
    logic        step_req;
    logic [15:0] step_count;
    logic        halt_req;
    logic        bp_we;
    logic [1:0]  bp_idx;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        cpu_en;
    logic [1:0]  state_o;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  bp_hit_idx;
    logic [31:0] retired_cnt;

    int   total = 0;
    int   bad   = 0;
    logic en_q [$];

    dp_run_ctrl #(
        .XLEN(32), .NUM_BP(4), .CNT_W(16), .RESET_RUN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .run_req(run_req), .step_req(step_req), .step_count(step_count),
        .halt_req(halt_req), .bp_we(bp_we), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_en(bp_en), .cpu_en(cpu_en),
        .state_o(state_o), .halted(halted), .bp_hit(bp_hit),
        .bp_hit_idx(bp_hit_idx), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: an eight-instruction loop 0x00..0x1C that only advances when enabled.
    always @(posedge clk) begin
        if (rst) pc_i <= 32'h0;
        else if (cpu_en) pc_i <= (pc_i == 32'h1C) ? 32'h0 : pc_i + 32'd4;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Queue the cpu_en this cycle must show, then advance past the next rising edge.
    task automatic applyStimulus(input logic exp_en);
        en_q.push_back(exp_en);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic exp_en;
        if (en_q.size() != 0) begin
            exp_en = en_q.pop_front();
            checkOutput("cpu_en", 32'(cpu_en), 32'(exp_en));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; run_req = 1'b0; step_req = 1'b0; step_count = 16'd0;
        halt_req = 1'b0; bp_we = 1'b0; bp_idx = 2'd0; bp_addr = 32'h0; bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_state", 32'(state_o), 32'd1);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_retired", retired_cnt, 32'd0);
        checkOutput("reset_bp_hit", 32'(bp_hit), 32'd0);
        checkOutput("reset_bp_idx", 32'(bp_hit_idx), 32'd0);
        checkOutput("reset_cpu_en", 32'(cpu_en), 32'd1);

        // free run
        repeat (10) applyStimulus(1'b1);
        checkOutput("run_retired", retired_cnt, 32'd10);
        checkOutput("run_halted", 32'(halted), 32'd0);

        halt_req = 1'b1;
        applyStimulus(1'b1);
        halt_req = 1'b0;
        checkOutput("halt_retired", retired_cnt, 32'd11);
        checkOutput("halt_state", 32'(state_o), 32'd0);

        // step burst of 3
        step_count = 16'd3; step_req = 1'b1;
        applyStimulus(1'b0);
        step_req = 1'b0;
        checkOutput("step_state", 32'(state_o), 32'd2);
        repeat (3) applyStimulus(1'b1);
        checkOutput("step3_halted", 32'(halted), 32'd1);
        checkOutput("step3_retired", retired_cnt, 32'd14);

        // zero count behaves as one
        step_count = 16'd0; step_req = 1'b1;
        applyStimulus(1'b0);
        step_req = 1'b0;
        applyStimulus(1'b1);
        checkOutput("step0_halted", 32'(halted), 32'd1);
        checkOutput("step0_retired", retired_cnt, 32'd15);
        applyStimulus(1'b0);

        // breakpoint at 0x10 in slots 2 and 3; lowest slot must be reported
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rerst_retired", retired_cnt, 32'd0);
        bp_we = 1'b1; bp_idx = 2'd2; bp_addr = 32'h10; bp_en = 1'b1;
        applyStimulus(1'b1);
        bp_idx = 2'd3;
        applyStimulus(1'b1);
        bp_we = 1'b0;
        repeat (2) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("bp_hit", 32'(bp_hit), 32'd1);
        checkOutput("bp_hit_idx", 32'(bp_hit_idx), 32'd2);
        checkOutput("bp_retired", retired_cnt, 32'd4);
        checkOutput("bp_halted", 32'(halted), 32'd1);
        applyStimulus(1'b0);
        checkOutput("bp_hit_pulse", 32'(bp_hit), 32'd0);
        checkOutput("bp_idx_held", 32'(bp_hit_idx), 32'd2);

        // resume from the breakpoint, loop around, stop there again
        run_req = 1'b1;
        applyStimulus(1'b0);
        run_req = 1'b0;
        repeat (8) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("rebp_hit", 32'(bp_hit), 32'd1);
        checkOutput("rebp_retired", retired_cnt, 32'd12);

        // halt_req together with a match: halt wins, no bp_hit
        run_req = 1'b1;
        applyStimulus(1'b0);
        run_req = 1'b0;
        repeat (8) applyStimulus(1'b1);
        halt_req = 1'b1;
        applyStimulus(1'b0);
        halt_req = 1'b0;
        checkOutput("prio_halted", 32'(halted), 32'd1);
        checkOutput("prio_bp_hit", 32'(bp_hit), 32'd0);
        checkOutput("prio_retired", retired_cnt, 32'd20);

        // reset in the middle of a 7-step burst, 5 steps left
        step_count = 16'd7; step_req = 1'b1;
        applyStimulus(1'b0);
        step_req = 1'b0;
        repeat (2) applyStimulus(1'b1);
        rst = 1'b1;
        applyStimulus(1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_state", 32'(state_o), 32'd1);
        checkOutput("mid_rst_retired", retired_cnt, 32'd0);
        checkOutput("mid_rst_bp_idx", 32'(bp_hit_idx), 32'd0);
        repeat (6) applyStimulus(1'b1);
        checkOutput("bp_cleared_halted", 32'(halted), 32'd0);
        checkOutput("bp_cleared_retired", retired_cnt, 32'd6);

        // counter wrap via preload
        halt_req = 1'b1;
        applyStimulus(1'b1);
        halt_req = 1'b0;
        dut.retired_cnt = 32'hFFFF_FFFF;
        step_count = 16'd1; step_req = 1'b1;
        applyStimulus(1'b0);
        step_req = 1'b0;
        applyStimulus(1'b1);
        checkOutput("wrap_retired", retired_cnt, 32'd0);
        checkOutput("wrap_halted", 32'(halted), 32'd1);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(en_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
